// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
// Requester vectors, round-robin pointer and FSM states.
package mem_arb_pkg;

  localparam int N_REQ = 4;
  localparam int PTR_W = $clog2(N_REQ);

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_ACCESS
  } arb_state_t;

  function automatic ptr_t onehot_idx(req_vec_t v);
    ptr_t idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) idx = ptr_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin picker: first eligible bit at or after rr_ptr.
// Purely combinational, one-hot result.
import mem_arb_pkg::*;

module rr_pick (
  input  req_vec_t eligible,
  input  ptr_t     rr_ptr,
  output req_vec_t winner,
  output logic     any_valid
);

  ptr_t idx;

  always_comb begin
    winner = '0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = rr_ptr + ptr_t'(i);
      if (winner == '0 && eligible[idx])
        winner[idx] = 1'b1;
    end
  end

  assign any_valid = |eligible;

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: round-robin grant, address-mux select,
// fixed-latency access sequencing and completion ack.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_wr,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] sel_addr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [N_REQ-1:0] ack,
  output logic             busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  ptr_t             rr_ptr, rr_ptr_n;
  req_vec_t         gnt_n, ack_n;
  logic             rd_n, wr_n, busy_n;

  req_vec_t eligible, winner;
  logic     any_valid;
  logic     win_wr;

  // A requester still holding req in its ack cycle must not win again.
  assign eligible = req & ~ack;
  assign win_wr   = |(req_wr & winner);

  rr_pick u_pick (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB_IDLE;
      cnt    <= '0;
      rr_ptr <= '0;
      gnt    <= '0;
      ack    <= '0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rr_ptr <= rr_ptr_n;
      gnt    <= gnt_n;
      ack    <= ack_n;
      mem_rd <= rd_n;
      mem_wr <= wr_n;
      busy   <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rr_ptr_n = rr_ptr;
    gnt_n    = gnt;
    ack_n    = '0;
    rd_n     = mem_rd;
    wr_n     = mem_wr;
    busy_n   = busy;
    unique case (state)
      ARB_IDLE: begin
        if (any_valid) begin
          state_n  = ARB_ACCESS;
          cnt_n    = CNT_LOAD;
          rr_ptr_n = onehot_idx(winner) + ptr_t'(1);
          gnt_n    = winner;
          ack_n    = (MEM_LAT == 1) ? winner : '0;
          rd_n     = ~win_wr;
          wr_n     = win_wr;
          busy_n   = 1'b1;
        end
      end
      ARB_ACCESS: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_ONE;
          ack_n = (cnt == CNT_ONE) ? gnt : '0;
        end else if (any_valid) begin
          // Back-to-back grant straight out of the ack cycle.
          cnt_n    = CNT_LOAD;
          rr_ptr_n = onehot_idx(winner) + ptr_t'(1);
          gnt_n    = winner;
          ack_n    = (MEM_LAT == 1) ? winner : '0;
          rd_n     = ~win_wr;
          wr_n     = win_wr;
          busy_n   = 1'b1;
        end else begin
          state_n = ARB_IDLE;
          gnt_n   = '0;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          busy_n  = 1'b0;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  assign sel_addr = gnt;

endmodule
